iq_frame_buffer: RTL and testbench
==================================

# iq_frame_buffer

Parametrised successor to the two-lane I/Q split buffer. It collects a serial stream of interleaved channel samples (I, Q, or more lanes) into complete frames, one sample per lane, and queues each frame as a single wide word in an internal synchronous FIFO. The output side uses a valid/ready handshake. The block sits between the ADC/sample front end and the downstream DSP/readout logic, and adds frame alignment, status flags and error reporting that the fixed two-lane version lacks.

## Interface
Parameters:
- DW, 12, sample width in bits.
- NCH, 2, lanes per frame; ≥1.
- DEPTH, 16, FIFO depth in frames; power of two, ≥2.
- MSB_FIRST, 1, 1: lane 0 occupies dout MSB slot; 0: lane 0 occupies LSB slot.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- sclr  in  1  synchronous active-high reset; clears assembler, FIFO and status.
- din  in  DW  input sample.
- din_valid  in  1  din is valid this cycle.
- din_sof  in  1  with din_valid: din is lane 0 of a new frame.
- clr_status  in  1  clears the sticky overflow and sof_err flags.
- dout  out  NCH*DW  head frame; lane k is at slot k (MSB_FIRST=0) or slot NCH-1-k (MSB_FIRST=1).
- dout_valid  out  1  FIFO non-empty; dout is valid.
- dout_ready  in  1  consumer accepts dout.
- level  out  $clog2(DEPTH)+1  frames stored.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- overflow  out  1  sticky; set when a completed frame was dropped.
- sof_err  out  1  sticky; set when a partial frame was discarded by din_sof.

## Operation
Assembler:
- A lane counter `lane` (0..NCH-1) holds the index of the next sample.
- On din_valid, din is written to lane slot `lane` of the staging register, and `lane` increments.
- When `lane`==NCH-1 accepts a sample, the frame is complete. The staging word is copied to the frame register, `frame_pend` is set for one cycle, and `lane` wraps to 0.
- din_sof with din_valid and `lane`≠0:
  - The partial frame is discarded and sof_err is set.
  - din is stored as lane 0 and `lane` becomes 1 (or the frame completes if NCH=1).
- din_sof with `lane`==0 is normal. din_sof without din_valid is ignored.
- NCH=1: every valid sample is a frame; sof_err never sets.

FIFO:
- push = frame_pend. pop = dout_valid & dout_ready.
- Push when full and no pop: the frame is dropped, overflow sets, and level is unchanged.
- Push and pop in the same cycle while full: both are accepted and level stays DEPTH.
- Push and pop in the same cycle while neither full nor empty: level is unchanged.
- Pop when empty is impossible, because dout_valid=0.
- Pointers wrap modulo DEPTH. level is updated by push − pop.

Output:
- dout always shows the head entry (first-word fall-through).
- dout is held stable while dout_valid & !dout_ready.

Status:
- clr_status clears overflow and sof_err.
- If a set event and clr_status occur in the same cycle, the set wins.

## Timing
- Reset values:
  - dout=0, dout_valid=0, level=0, full=0, empty=1, overflow=0, sof_err=0.
  - `lane`=0, frame_pend=0, FIFO pointers=0.
- sclr during a partial frame discards the partial frame. Inputs presented in the sclr cycle are ignored.
- Latency: the last lane sample is accepted in cycle n, frame_pend is high in cycle n+1, and the FIFO is written at the end of n+1. With the FIFO empty, dout_valid=1 and the frame appears on dout in cycle n+2.
- Throughput: one sample per cycle sustained; one frame per NCH cycles.
- level, full and empty are registered and reflect pushes and pops of the previous cycle.
- overflow and sof_err assert in the cycle after the causing event.

## Structure
- Package `iq_buf_pkg`:
  - LEVEL_W function, i.e. $clog2(DEPTH)+1.
  - Lane-slot index function, which handles MSB_FIRST.
  - Default DW/NCH/DEPTH constants.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH; ports clk, sclr, wr_en, wr_data, rd_en, rd_data (FWFT), level, full, empty. It is instantiated once with WIDTH=NCH*DW.
- The assembler, frame register and status flags live in the top level.

## Test plan
- DW=12, NCH=2, MSB_FIRST=1. Stream 0x111, 0x222 with sof on the first sample, dout_ready=1. Required: dout=0x111222 with dout_valid in cycle n+2, then empty=1.
- NCH=4, DEPTH=4, dout_ready=0. Push 5 complete frames. Required: level=4, full=1, fifth frame dropped, overflow=1. Then pulse clr_status: overflow=0, and the 4 frames drain in order.
- NCH=2. Send 0xAAA, then 0xBBB with sof. Required: sof_err=1, and the next frame is 0xBBB plus the following sample; 0xAAA is never output.
- Full FIFO, dout_ready=1, and a frame completing on the same cycle as a pop. Required: level stays DEPTH, no overflow, order is preserved.
- Random valid/sof/ready back-pressure for 10k cycles against a scoreboard model. Required: no loss except counted drops, and dout stable while stalled.
- Assert sclr mid-frame with 3 frames queued. Required: all outputs at reset values next cycle. A new frame afterwards starts at lane 0.

Source files
------------

// File: rtl/iq_buf_pkg.sv
// Shared constants and helpers for the I/Q frame buffer and its FIFO.
package iq_buf_pkg;

   localparam int DW_DEF    = 12;
   localparam int NCH_DEF   = 2;
   localparam int DEPTH_DEF = 16;

   // Width of a level counter that must be able to hold the value DEPTH.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of an index over n items (at least one bit, so NCH=1 stays legal).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Slot of the output word that a lane occupies. With msb_first,
   // lane 0 sits in the most significant slot.
   function automatic int lane_slot(input int lane, input int nch, input bit msb_first);
      return msb_first ? (nch - 1 - lane) : lane;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered level/full/empty.
// A write while full is accepted only if a read frees the head slot in the
// same cycle; otherwise it is discarded and the caller flags the drop.
module sync_fifo
   import iq_buf_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      sclr,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic [level_w(DEPTH)-1:0] level,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;
   logic [LW-1:0]    level_nxt;

   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // Next occupancy from this cycle's accepted write/read.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      level_nxt = level;
      if (do_wr && !do_rd) begin
         level_nxt = level + 1'b1;
      end else if (do_rd && !do_wr) begin
         level_nxt = level - 1'b1;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; rd_data is masked while empty instead.
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and registered status; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk) begin
      if (sclr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/iq_frame_buffer.sv
// Assembles a serial stream of interleaved lane samples into whole frames and
// queues each frame as one wide word behind a valid/ready output.
module iq_frame_buffer
   import iq_buf_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int NCH       = NCH_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MSB_FIRST = 1
) (
   input  logic                      clk,
   input  logic                      sclr,
   input  logic [DW-1:0]             din,
   input  logic                      din_valid,
   input  logic                      din_sof,
   input  logic                      clr_status,
   output logic [NCH*DW-1:0]         dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [level_w(DEPTH)-1:0] level,
   output logic                      full,
   output logic                      empty,
   output logic                      overflow,
   output logic                      sof_err
);

   localparam int                FW     = NCH * DW;
   localparam int                LANE_W = idx_w(NCH);
   localparam bit                MSB    = (MSB_FIRST != 0);
   localparam logic [LANE_W-1:0] LAST   = LANE_W'(NCH - 1);

   logic [LANE_W-1:0] lane;
   logic [LANE_W-1:0] eff_lane;
   logic [FW-1:0]     stage;
   logic [FW-1:0]     stage_nxt;
   logic [FW-1:0]     frame_reg;
   logic              frame_pend;
   logic              frame_done;
   logic              sof_restart;
   logic              pop;
   logic              drop;

   // Place the incoming sample into its lane slot; din_sof realigns to lane 0.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' so later statements see earlier updates; registers use '<='.
      eff_lane  = din_sof ? '0 : lane;
      stage_nxt = stage;
      for (int k = 0; k < NCH; k++) begin
         if (eff_lane == LANE_W'(k)) begin
            stage_nxt[lane_slot(k, NCH, MSB)*DW +: DW] = din;
         end
      end
   end

   assign frame_done  = din_valid & (eff_lane == LAST);
   assign sof_restart = din_valid & din_sof & (lane != '0);

   // Lane counter, staging word and one-cycle hand-off of a completed frame.
   always_ff @(posedge clk) begin
      if (sclr) begin
         lane       <= '0;
         stage      <= '0;
         frame_reg  <= '0;
         frame_pend <= 1'b0;
      end else begin
         frame_pend <= frame_done;
         if (din_valid) begin
            stage <= stage_nxt;
            if (frame_done) begin
               lane      <= '0;
               frame_reg <= stage_nxt;
            end else begin
               lane <= eff_lane + 1'b1;
            end
         end
      end
   end

   assign pop  = dout_valid & dout_ready;
   assign drop = frame_pend & full & ~pop;

   // Sticky error flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (sclr) begin
         overflow <= 1'b0;
         sof_err  <= 1'b0;
      end else begin
         overflow <= (overflow & ~clr_status) | drop;
         sof_err  <= (sof_err & ~clr_status) | sof_restart;
      end
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .sclr    (sclr),
      .wr_en   (frame_pend),
      .wr_data (frame_reg),
      .rd_en   (pop),
      .rd_data (dout),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   assign dout_valid = ~empty;

endmodule

// File: tb/tb_iq_frame_buffer.sv
// Self-checking bench: a queue-based reference model predicts which frames
// enter the buffer; a monitor pops expectations whenever dout is accepted.
module tb_iq_frame_buffer;

   localparam int DW        = 12;
   localparam int NCH       = 2;
   localparam int DEPTH     = 4;
   localparam int MSB_FIRST = 1;
   localparam int FW        = NCH * DW;
   localparam int LW        = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          sclr;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          din_sof;
   logic          clr_status;
   logic [FW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          sof_err;

   int n_checks = 0;
   int n_fail   = 0;

   iq_frame_buffer #(
      .DW        (DW),
      .NCH       (NCH),
      .DEPTH     (DEPTH),
      .MSB_FIRST (MSB_FIRST)
   ) dut (
      .clk        (clk),
      .sclr       (sclr),
      .din        (din),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .clr_status (clr_status),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .sof_err    (sof_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: samples collect in a list until NCH arrive, frames
   // queue in sb, occ counts frames held by the buffer.
   logic [DW-1:0] part[$];
   logic [FW-1:0] sb[$];
   int            occ = 0;
   bit            pend = 0;
   logic [FW-1:0] pend_word;
   bit            m_ov = 0;
   bit            m_se = 0;
   int            drops = 0;
   bit            pop_now, drop_now, sof_ev;
   logic [FW-1:0] w;

   always @(posedge clk) begin
      if (sclr) begin
         part.delete();
         sb.delete();
         occ  = 0;
         pend = 0;
         m_ov = 0;
         m_se = 0;
      end else begin
         pop_now  = (occ > 0) && dout_ready;
         drop_now = pend && (occ == DEPTH) && !pop_now;
         if (pop_now) occ--;
         if (pend && !drop_now) begin
            occ++;
            sb.push_back(pend_word);
         end
         if (drop_now) drops++;
         sof_ev = 0;
         pend   = 0;
         if (din_valid) begin
            if (din_sof && part.size() != 0) begin
               sof_ev = 1;
               part.delete();
            end
            part.push_back(din);
            if (part.size() == NCH) begin
               w = '0;
               for (int k = 0; k < NCH; k++) begin
                  if (MSB_FIRST != 0) w = (w << DW) | FW'(part[k]);
                  else                w = w | (FW'(part[k]) << (k * DW));
               end
               pend      = 1;
               pend_word = w;
               part.delete();
            end
         end
         m_ov = (m_ov && !clr_status) || drop_now;
         m_se = (m_se && !clr_status) || sof_ev;
      end
   end

   // Monitor: flags every cycle, frame contents on every accepted transfer.
   bit            mon_en = 0;
   bit            stall_prev = 0;
   logic [FW-1:0] prev_dout;

   always @(negedge clk) begin
      if (mon_en) begin
         check("dout_valid", 64'(dout_valid), 64'(occ > 0));
         check("level", 64'(level), 64'(occ));
         check("full", 64'(full), 64'(occ == DEPTH));
         check("empty", 64'(empty), 64'(occ == 0));
         check("overflow", 64'(overflow), 64'(m_ov));
         check("sof_err", 64'(sof_err), 64'(m_se));
         if (stall_prev && dout_valid) check("dout_stable", 64'(dout), 64'(prev_dout));
         if (dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_pop: got frame 0x%0h, expected no frame", dout);
            end else begin
               check("dout", 64'(dout), 64'(sb.pop_front()));
            end
         end
         stall_prev = dout_valid && !dout_ready;
         prev_dout  = dout;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit sof);
      din       = d;
      din_valid = 1'b1;
      din_sof   = sof;
      tick();
      din_valid = 1'b0;
      din_sof   = 1'b0;
   endtask

   task automatic drain(input string name);
      dout_ready = 1'b1;
      for (int i = 0; i < 40 && !(empty && occ == 0); i++) tick();
      @(negedge clk);
      check(name, 64'(empty), 64'(1));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_dout"}, 64'(dout), 64'(0));
      check({tag, "_valid"}, 64'(dout_valid), 64'(0));
      check({tag, "_level"}, 64'(level), 64'(0));
      check({tag, "_full"}, 64'(full), 64'(0));
      check({tag, "_empty"}, 64'(empty), 64'(1));
      check({tag, "_ovf"}, 64'(overflow), 64'(0));
      check({tag, "_soferr"}, 64'(sof_err), 64'(0));
   endtask

   initial begin
      sclr = 1'b1; din = '0; din_valid = 1'b0; din_sof = 1'b0;
      clr_status = 1'b0; dout_ready = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check_reset("rst");
      sclr   = 1'b0;
      mon_en = 1;
      tick();

      // Basic frame and latency: last sample in cycle n, output in n+2.
      dout_ready = 1'b1;
      send(12'h111, 1'b1);
      send(12'h222, 1'b0);
      @(negedge clk);
      check("lat_n1_valid", 64'(dout_valid), 64'(0));
      tick();
      @(negedge clk);
      check("lat_valid", 64'(dout_valid), 64'(1));
      check("lat_dout", 64'(dout), 64'(24'h111222));
      tick();
      @(negedge clk);
      check("lat_empty", 64'(empty), 64'(1));
      tick();

      // Overflow: five frames into a four-deep buffer with no consumer.
      dout_ready = 1'b0;
      for (int f = 0; f < 5; f++) begin
         send(DW'(16 * f + 1), 1'b1);
         send(DW'(16 * f + 2), 1'b0);
      end
      tick();
      @(negedge clk);
      check("ovf_level", 64'(level), 64'(4));
      check("ovf_full", 64'(full), 64'(1));
      check("ovf_flag", 64'(overflow), 64'(1));
      tick();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      @(negedge clk);
      check("ovf_clr", 64'(overflow), 64'(0));
      check("ovf_head", 64'(dout), 64'(24'h001002));
      tick();
      drain("ovf_drain");
      tick();

      // Early sof discards the partial frame.
      send(12'hAAA, 1'b1);
      send(12'hBBB, 1'b1);
      @(negedge clk);
      check("soferr_set", 64'(sof_err), 64'(1));
      send(12'hCCC, 1'b0);
      tick();
      @(negedge clk);
      check("soferr_frame", 64'(dout), 64'(24'hBBBCCC));
      tick();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      @(negedge clk);
      check("soferr_clr", 64'(sof_err), 64'(0));
      tick();

      // Full buffer: a push coincides with a pop.
      dout_ready = 1'b0;
      for (int f = 0; f < 4; f++) begin
         send(DW'(12'h300 + f), 1'b1);
         send(DW'(12'h310 + f), 1'b0);
      end
      send(12'h3A0, 1'b1);
      send(12'h3B0, 1'b0);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      @(negedge clk);
      check("fullpp_level", 64'(level), 64'(4));
      check("fullpp_full", 64'(full), 64'(1));
      check("fullpp_ovf", 64'(overflow), 64'(0));
      check("fullpp_head", 64'(dout), 64'(24'h301311));
      tick();
      drain("fullpp_drain");
      tick();

      // Random traffic with varying back-pressure.
      for (int blk = 0; blk < 10; blk++) begin
         int rdy_pct;
         rdy_pct = 20 + 15 * (blk % 6);
         for (int c = 0; c < 1000; c++) begin
            din        = DW'($urandom_range(0, 4095));
            din_valid  = ($urandom_range(0, 3) != 0);
            din_sof    = ($urandom_range(0, 7) == 0);
            dout_ready = ($urandom_range(0, 99) < rdy_pct);
            clr_status = ($urandom_range(0, 49) == 0);
            tick();
         end
      end
      din_valid = 1'b0; din_sof = 1'b0; clr_status = 1'b0;
      drain("rand_drain");
      tick();

      // sclr mid-frame with three frames queued; sclr-cycle inputs ignored.
      dout_ready = 1'b0;
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      for (int f = 0; f < 3; f++) begin
         send(DW'(12'h700 + f), 1'b1);
         send(DW'(12'h710 + f), 1'b0);
      end
      tick();
      send(12'h7FF, 1'b1);
      sclr      = 1'b1;
      din       = 12'h5A5;
      din_valid = 1'b1;
      tick();
      sclr      = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      check_reset("sclr");
      send(12'h123, 1'b0);
      send(12'h456, 1'b0);
      dout_ready = 1'b1;
      tick();
      @(negedge clk);
      check("sclr_newframe", 64'(dout), 64'(24'h123456));
      tick();
      repeat (3) tick();

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
